// File: rtl/load_store_unit_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : load_store_unit_pkg
// Brief    : Shared access-size codes, FSM encodings and store lane helpers.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package load_store_unit_pkg;

    // Same size encoding as the controller's maskSel/loadSel.
    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            MASK_BYTE: r = 1'b0;
            MASK_HALF: r = off[0];
            MASK_WORD: r = (off != 2'b00);
            default:   r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] r;
        case (size)
            MASK_BYTE: r = 4'b0001 << off;
            MASK_HALF: r = off[1] ? 4'b1100 : 4'b0011;
            default:   r = 4'b1111;
        endcase
        return r;
    endfunction

    // Replicating the data across lanes lets the strobes alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] r;
        case (size)
            MASK_BYTE: r = {4{wdata[7:0]}};
            MASK_HALF: r = {2{wdata[15:0]}};
            default:   r = wdata;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_formatter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : load_formatter
// Brief    : Aligns a read word by byte offset and sign/zero-extends byte/half.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module load_formatter
    import load_store_unit_pkg::*;
(
    input  logic [31:0] memRData,
    input  logic [1:0]  offset,
    input  logic [1:0]  maskSel,
    input  logic        uext,
    output logic [31:0] data_out
);

    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;

    always_comb begin
        w_shifted = memRData >> {offset, 3'b000};
        w_sign_b  = ~uext & w_shifted[7];
        w_sign_h  = ~uext & w_shifted[15];
        case (maskSel)
            MASK_BYTE: data_out = {{24{w_sign_b}}, w_shifted[7:0]};
            MASK_HALF: data_out = {{16{w_sign_h}}, w_shifted[15:0]};
            default:   data_out = memRData;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : load_store_unit
// Brief    : Converts core load/store requests into strobed req/ack word accesses.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  maskSel,
    input  logic        uext,
    output logic        stall,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        busError,
    output logic        memReq,
    output logic [3:0]  memWe,
    output logic [29:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,      state_d;
    logic        ready_q,      ready_d;
    logic [31:0] rdata_q,      rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_error_q,  bus_error_d;
    logic        mem_req_q,    mem_req_d;
    logic [3:0]  mem_we_q,     mem_we_d;
    logic [29:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic [1:0]  off_q,        off_d;
    logic [1:0]  size_q,       size_d;
    logic        uext_q,       uext_d;
    logic        we_q,         we_d;

    logic [31:0] w_load_data;

    load_formatter u_load_formatter (
        .memRData (memRData),
        .offset   (off_q),
        .maskSel  (size_q),
        .uext     (uext_q),
        .data_out (w_load_data)
    );

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        rdata_d      = 32'h0;
        misaligned_d = 1'b0;
        bus_error_d  = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uext_d       = uext_q;
        we_d         = we_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (is_misaligned(maskSel, addr[1:0])) begin
                        ready_d      = 1'b1;
                        misaligned_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = we ? store_strobe(maskSel, addr[1:0]) : 4'b0000;
                        mem_addr_d  = addr[31:2];
                        mem_wdata_d = store_data(maskSel, wdata);
                        off_d       = addr[1:0];
                        size_d      = maskSel;
                        uext_d      = uext;
                        we_d        = we;
                        cnt_d       = 8'd0;
                        state_d     = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // An ack on the final counted cycle wins over the timeout.
                if (memAck) begin
                    mem_req_d = 1'b0;
                    ready_d   = 1'b1;
                    rdata_d   = we_q ? 32'h0 : w_load_data;
                    state_d   = ST_DONE;
                end else if (cnt_q == C_CNT_LAST) begin
                    mem_req_d   = 1'b0;
                    ready_d     = 1'b1;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            rdata_q      <= 32'h0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 4'h0;
            mem_addr_q   <= 30'h0;
            mem_wdata_q  <= 32'h0;
            cnt_q        <= 8'd0;
            off_q        <= 2'b00;
            size_q       <= 2'b00;
            uext_q       <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uext_q       <= uext_d;
            we_q         <= we_d;
        end
    end

    assign stall      = req & ~ready_q;
    assign ready      = ready_q;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign busError   = bus_error_q;
    assign memReq     = mem_req_q;
    assign memWe      = mem_we_q;
    assign memAddr    = mem_addr_q;
    assign memWData   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit (TIMEOUT = 4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  maskSel;
    logic        uext;
    logic        stall;
    logic        ready;
    logic [31:0] rdata;
    logic        misaligned;
    logic        busError;
    logic        memReq;
    logic [3:0]  memWe;
    logic [29:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    int n_vec  = 0;
    int n_miss = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .maskSel    (maskSel),
        .uext       (uext),
        .stall      (stall),
        .ready      (ready),
        .rdata      (rdata),
        .misaligned (misaligned),
        .busError   (busError),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memRData   (memRData),
        .memAck     (memAck)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ack_dly: number of memReq-high cycles before the ack cycle; -1 = never ack.
    task automatic run_access(input string tag, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [1:0] ms, input logic ue,
                              input int ack_dly, input logic [31:0] rd,
                              input logic [31:0] exp_rdata, input logic exp_mis,
                              input logic exp_berr, input logic [3:0] exp_we,
                              input logic [31:0] exp_wdata, input int exp_lat,
                              input int exp_reqc);
        int lat  = 0;
        int reqc = 0;
        bit got  = 0;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = wd; maskSel = ms; uext = ue; memAck = 1'b0;
        #1 check_vec({tag, "_stall"}, 32'(stall), 32'd1);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            memAck = 1'b0;
            if (ready) begin
                got = 1;
            end else if (memReq) begin
                check_vec({tag, "_memWe"},    32'(memWe),   32'(exp_we));
                check_vec({tag, "_memAddr"},  32'(memAddr), 32'(a[31:2]));
                check_vec({tag, "_memWData"}, memWData,     exp_wdata);
                if (reqc == ack_dly) begin
                    memAck   = 1'b1;
                    memRData = rd;
                end else begin
                    memRData = 32'hDEAD_BEEF;
                end
                reqc++;
            end
        end
        if (!got) begin
            check_vec({tag, "_ready_wait"}, 32'd0, 32'd1);
        end else begin
            check_vec({tag, "_rdata"},   rdata,            exp_rdata);
            check_vec({tag, "_mis"},     32'(misaligned),  32'(exp_mis));
            check_vec({tag, "_berr"},    32'(busError),    32'(exp_berr));
            check_vec({tag, "_lat"},     32'(lat),         32'(exp_lat));
            check_vec({tag, "_reqc"},    32'(reqc),        32'(exp_reqc));
            check_vec({tag, "_stall0"},  32'(stall),       32'd0);
        end
        req = 1'b0;
        memAck = 1'b0;
        @(negedge clk);
        check_vec({tag, "_ready_off"}, {29'd0, ready, misaligned, busError}, 32'd0);
        check_vec({tag, "_req_off"},   32'(memReq), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
        maskSel = 2'b00; uext = 1'b0; memRData = 32'h0; memAck = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("rst_flags",  {28'd0, ready, misaligned, busError, memReq}, 32'd0);
        check_vec("rst_rdata",  rdata,           32'd0);
        check_vec("rst_memWe",  32'(memWe),      32'd0);
        check_vec("rst_addr",   32'(memAddr),    32'd0);
        check_vec("rst_wdata",  memWData,        32'd0);
        reset = 1'b0;

        run_access("bld_sext",  0, 32'h0000_1003, 32'h0, 2'b00, 0, 1, 32'h80FF_1234,
                   32'hFFFF_FF80, 0, 0, 4'b0000, 32'h0, 3, 2);
        run_access("hld_zext",  0, 32'h0000_2002, 32'h0, 2'b01, 1, 0, 32'hBEEF_0000,
                   32'h0000_BEEF, 0, 0, 4'b0000, 32'h0, 2, 1);
        run_access("bst",       1, 32'h0000_0011, 32'hAABB_CCDD, 2'b00, 0, 2, 32'hFFFF_FFFF,
                   32'h0, 0, 0, 4'b0010, 32'hDDDD_DDDD, 4, 3);
        run_access("mis_word",  0, 32'h0000_0006, 32'h0, 2'b10, 0, 0, 32'h1111_1111,
                   32'h0, 1, 0, 4'b0000, 32'h0, 1, 0);
        run_access("timeout",   0, 32'h0000_0100, 32'h0, 2'b10, 0, -1, 32'h2222_2222,
                   32'h0, 0, 1, 4'b0000, 32'h0, 5, 4);
        run_access("ack_last",  0, 32'h0000_0104, 32'h0, 2'b10, 0, 3, 32'h1234_5678,
                   32'h1234_5678, 0, 0, 4'b0000, 32'h0, 5, 4);
        run_access("hst_hi",    1, 32'h0000_0022, 32'h0000_5A6B, 2'b01, 0, 0, 32'h3333_3333,
                   32'h0, 0, 0, 4'b1100, 32'h5A6B_5A6B, 2, 1);
        run_access("hld_sext",  0, 32'h0000_0000, 32'h0, 2'b01, 0, 0, 32'h1234_8001,
                   32'hFFFF_8001, 0, 0, 4'b0000, 32'h0, 2, 1);
        run_access("illegal",   0, 32'h0000_0000, 32'h0, 2'b11, 0, 0, 32'h4444_4444,
                   32'h0, 1, 0, 4'b0000, 32'h0, 1, 0);
        run_access("wst",       1, 32'h0000_3000, 32'hCAFE_F00D, 2'b10, 0, 1, 32'h5555_5555,
                   32'h0, 0, 0, 4'b1111, 32'hCAFE_F00D, 3, 2);
        run_access("bld_zext",  0, 32'h0000_1002, 32'h0, 2'b00, 1, 0, 32'h00A5_0000,
                   32'h0000_00A5, 0, 0, 4'b0000, 32'h0, 2, 1);
        run_access("mis_half",  1, 32'h0000_0003, 32'h0, 2'b01, 0, 0, 32'h0,
                   32'h0, 1, 0, 4'b0000, 32'h0, 1, 0);

        // Reset while a word load is outstanding.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0000_0040; maskSel = 2'b10; uext = 1'b0;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (memReq) seen = 1;
            end
            check_vec("rstmid_memReq_up", 32'(seen), 32'd1);
        end
        reset = 1'b1;
        #1;
        check_vec("rstmid_flags", {28'd0, ready, misaligned, busError, memReq}, 32'd0);
        check_vec("rstmid_memWe", 32'(memWe), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req = 1'b0;
        @(negedge clk);
        memAck = 1'b1;
        memRData = 32'h7777_7777;
        @(negedge clk);
        memAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_vec("late_ack_ready", {30'd0, ready, memReq}, 32'd0);
            @(negedge clk);
        end

        run_access("post_rst",  0, 32'h0000_0080, 32'h0, 2'b10, 0, 0, 32'h0BAD_F00D,
                   32'h0BAD_F00D, 0, 0, 4'b0000, 32'h0, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side responder for the core's data-access control signals: write enable, access size, unsigned-extend flag, and the ALU-computed address.
- Turns one core load/store request into a byte-strobed word transaction on a req/ack data-memory port.
- Returns aligned, sign- or zero-extended load data.
- Stalls the core until the transaction completes, flags misaligned accesses, and flags a memory bus timeout.
- Sits between the core datapath (controller/ALU outputs) and the data RAM or bus fabric.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for memAck before aborting with busError; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  core requests an access; held stable until ready.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- maskSel  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- uext  in  1  1 = zero-extend load, 0 = sign-extend.
- stall  out  1  combinational: req & ~ready.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  formatted load data, valid while ready; 0 for stores.
- misaligned  out  1  one-cycle pulse together with ready.
- busError  out  1  one-cycle pulse together with ready.
- memReq  out  1  memory request.
- memWe  out  4  byte write strobes; 0000 on reads.
- memAddr  out  30  word address, addr[31:2].
- memWData  out  32  lane-replicated store data.
- memRData  in  32  read word, valid when memAck.
- memAck  in  1  memory completes the request; a single-cycle pulse.

Behaviour:
- Reset: asynchronous, active-high, fixed polarity. Clears state to IDLE and all registered outputs (ready, rdata, misaligned, busError, memReq, memWe, memAddr, memWData, timeout counter) to 0. Reset mid-transaction abandons it; an ack arriving after reset is ignored.
- Alignment check: misaligned if maskSel==01 & addr[0]; or maskSel==10 & addr[1:0]!=0; or maskSel==11.
- Store lanes:
  - byte: memWData = {4{wdata[7:0]}}, memWe = 0001<<addr[1:0].
  - half: memWData = {2{wdata[15:0]}}, memWe = addr[1] ? 1100 : 0011.
  - word: memWData = wdata, memWe = 1111.
- Load format: shifted = memRData >> (8*addr[1:0]). Byte/half take the low 8/16 bits of shifted. Extension uses bit 7/15 when uext=0 and zeros when uext=1. Word passes through unchanged.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req & aligned: register memAddr, memWe (0000 if load), memWData, latched addr[1:0], maskSel and uext. Assert memReq next cycle, clear the counter, go to BUSY.
  - req & misaligned: next cycle ready=1 and misaligned=1, no memReq, go to DONE.
  - no req: stay.
- BUSY:
  - memReq held at 1; memAddr, memWe and memWData held stable.
  - memAck: drop memReq next cycle. Register rdata (formatted for loads, 0 for stores) and pulse ready. Go to DONE.
  - Otherwise the counter increments. On the cycle the counter reaches TIMEOUT-1 without an ack: drop memReq, pulse ready and busError, rdata=0, go to DONE.
  - memAck on the exact timeout cycle counts as success: no busError.
- DONE: lasts one cycle; ready and flags deassert, then return to IDLE. The core advances on ready, so the still-high old req is never re-issued. A new req is accepted in IDLE on the next cycle.
- Latency: a successful access takes 2 + (ack delay) cycles from req to ready. With a same-cycle ack after memReq, ready comes 2 cycles after req.
- Ack outside BUSY is ignored.
- we=1 with rdata: rdata stays 0.

Decomposition:
- Shared constants header: MASK_BYTE=2'b00, MASK_HALF=2'b01, MASK_WORD=2'b10, plus state encodings IDLE/BUSY/DONE. The same size encodings are used by the controller's maskSel/loadSel.
- One sub-module, load_formatter: combinational. Inputs memRData, offset[1:0], maskSel and uext; output is the extended 32-bit word. It is reusable for a future instruction-fetch alignment path.

Test Plan:
- Byte load sign-extend: addr=0x1003, maskSel=00, uext=0, memRData=0x80FF_1234, ack 1 cycle after memReq -> memWe=0000, memAddr=0x400, ready with rdata=0xFFFF_FF80.
- Half load zero-extend: addr=0x2002, maskSel=01, uext=1, memRData=0xBEEF_0000 -> rdata=0x0000_BEEF.
- Byte store: addr=0x11, wdata=0xAABB_CCDD, maskSel=00 -> memWe=0010, memWData=0xDDDD_DDDD, held until ack. Ready pulses exactly once and rdata=0.
- Misaligned: word load at addr=0x6 -> memReq never asserts, ready and misaligned pulse together one cycle after req.
- Timeout: TIMEOUT=4, memAck held low -> memReq high 4 cycles, then busError and ready pulse, state returns to IDLE. Repeat with ack on the 4th cycle -> no busError.
- Reset mid-BUSY: assert reset while memReq=1 -> memReq, ready and all flags are 0 immediately. A late ack produces no ready. A fresh word load afterwards completes normally.
